// File: rtl/muldiv_pkg.sv
// Shared constants for the iterative multiply/divide unit: ALU operation codes,
// FSM state type and iteration count.
package muldiv_pkg;

    // Operation codes mirrored unchanged from the shared ALU defines.
    localparam logic [3:0] ALU_MUL = 4'hA;
    localparam logic [3:0] ALU_DIV = 4'hB;
    localparam logic [3:0] ALU_MOD = 4'hC;

    localparam int unsigned ITERATIONS = 32;
    localparam logic [4:0]  ITER_LAST  = 5'(ITERATIONS - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_e;

endpackage

// File: rtl/muldiv.sv
// Multi-cycle unsigned multiply/divide/modulo: one bit per cycle, fixed
// 32-iteration latency, valid/ready request and response handshakes.
module muldiv
    import muldiv_pkg::*;
(
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_valid,
    output logic        o_ready,
    input  logic [31:0] i_op1,
    input  logic [31:0] i_op2,
    input  logic [3:0]  i_ctl,
    output logic        o_valid,
    input  logic        i_ready,
    output logic [31:0] o_res
);

    state_e      state_q, state_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [3:0]  ctl_q, ctl_d;
    logic [31:0] a_q, a_d;     // multiplicand / quotient
    logic [31:0] b_q, b_d;     // multiplier / divisor
    logic [31:0] acc_q, acc_d; // product accumulator / remainder low bits
    logic [31:0] res_q, res_d;

    logic        is_div;
    logic [31:0] add_x, add_y;
    logic [32:0] sum;
    logic        r_ge;

    // Shared adder: add for MUL, subtract for DIV. The shifted remainder is
    // 33 bits; its top bit (acc_q[31]) forces R >= divisor on its own.
    assign is_div = (ctl_q == ALU_DIV) || (ctl_q == ALU_MOD);
    assign add_x  = is_div ? {acc_q[30:0], a_q[31]} : acc_q;
    assign add_y  = is_div ? ~b_q : a_q;
    assign sum    = {1'b0, add_x} + {1'b0, add_y} + {32'b0, is_div};
    assign r_ge   = acc_q[31] | sum[32];

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ctl_d   = ctl_q;
        a_d     = a_q;
        b_d     = b_q;
        acc_d   = acc_q;
        res_d   = res_q;
        case (state_q)
            ST_IDLE: begin
                if (i_valid) begin
                    state_d = ST_BUSY;
                    cnt_d   = ITER_LAST;
                    ctl_d   = i_ctl;
                    a_d     = i_op1;
                    b_d     = i_op2;
                    acc_d   = '0;
                end
            end
            ST_BUSY: begin
                if (is_div) begin
                    acc_d = r_ge ? sum[31:0] : add_x;
                    a_d   = {a_q[30:0], r_ge};
                end else begin
                    if (b_q[0]) begin
                        acc_d = sum[31:0];
                    end
                    a_d = {a_q[30:0], 1'b0};
                    b_d = {1'b0, b_q[31:1]};
                end
                if (cnt_q == 5'd0) begin
                    state_d = ST_DONE;
                    case (ctl_q)
                        ALU_MUL: res_d = acc_d;
                        ALU_DIV: res_d = a_d;
                        ALU_MOD: res_d = acc_d;
                        default: res_d = '0;
                    endcase
                end else begin
                    cnt_d = cnt_q - 5'd1;
                end
            end
            ST_DONE: begin
                if (i_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            ctl_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            acc_q   <= '0;
            res_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ctl_q   <= ctl_d;
            a_q     <= a_d;
            b_q     <= b_d;
            acc_q   <= acc_d;
            res_q   <= res_d;
        end
    end

    assign o_ready = (state_q == ST_IDLE);
    assign o_valid = (state_q == ST_DONE);
    assign o_res   = res_q;

endmodule

// File: tb/tb_muldiv.sv
// Self-checking bench for muldiv: vector table with a result scoreboard, plus
// back-pressure and mid-operation reset sequences.
module tb_muldiv;
    import muldiv_pkg::*;

    logic        i_clk = 1'b0;
    logic        i_rst_n = 1'b0;
    logic        i_valid = 1'b0;
    logic        o_ready;
    logic [31:0] i_op1 = '0;
    logic [31:0] i_op2 = '0;
    logic [3:0]  i_ctl = '0;
    logic        o_valid;
    logic        i_ready = 1'b0;
    logic [31:0] o_res;

    muldiv dut (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_valid (i_valid),
        .o_ready (o_ready),
        .i_op1   (i_op1),
        .i_op2   (i_op2),
        .i_ctl   (i_ctl),
        .o_valid (o_valid),
        .i_ready (i_ready),
        .o_res   (o_res)
    );

    always #5 i_clk = ~i_clk;

    typedef struct {
        logic [3:0]  ctl;
        logic [31:0] op1;
        logic [31:0] op2;
        logic [31:0] exp;
    } vec_t;

    int unsigned errors = 0;
    int unsigned checks = 0;
    logic [31:0] sb_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Drive one request starting at a negedge; returns at the negedge after
    // the accepting edge with the inputs already scrambled.
    task automatic issue(input logic [3:0] ctl, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp, input bit push);
        check("ready_before_issue", {31'b0, o_ready}, 32'd1);
        i_valid = 1'b1;
        i_ctl   = ctl;
        i_op1   = a;
        i_op2   = b;
        @(posedge i_clk);
        @(negedge i_clk);
        i_valid = 1'b0;
        i_ctl   = 4'($urandom);
        i_op1   = $urandom;
        i_op2   = $urandom;
        if (push) sb_q.push_back(exp);
    endtask

    task automatic wait_result(input string name);
        int lat = 0;
        while (!o_valid && lat < 100) begin
            @(posedge i_clk);
            lat++;
            @(negedge i_clk);
        end
        check({name, "_latency"}, 32'(lat), 32'd32);
    endtask

    task automatic drain(input string name);
        logic [31:0] exp;
        i_ready = 1'b1;
        if (sb_q.size() == 0) begin
            check({name, "_sb_empty"}, 32'd0, 32'd1);
            exp = '0;
        end else begin
            exp = sb_q.pop_front();
        end
        check({name, "_res"}, o_res, exp);
        @(posedge i_clk);
        @(negedge i_clk);
        check({name, "_ready_after"}, {30'b0, o_ready, o_valid}, 32'd2);
    endtask

    vec_t vecs[11];
    logic [31:0] bp_exp;

    initial begin
        vecs[0]  = '{ALU_MUL, 32'd7,          32'd6,       32'd42};
        vecs[1]  = '{ALU_MUL, 32'hFFFFFFFF,   32'd2,       32'hFFFFFFFE};
        vecs[2]  = '{ALU_MUL, 32'h00010000,   32'h00010000, 32'h0};
        vecs[3]  = '{ALU_MUL, 32'h12345678,   32'd9,       32'hA3D70A38};
        vecs[4]  = '{ALU_DIV, 32'd100,        32'd7,       32'd14};
        vecs[5]  = '{ALU_MOD, 32'd100,        32'd7,       32'd2};
        vecs[6]  = '{ALU_DIV, 32'hFFFFFFFF,   32'd1,       32'hFFFFFFFF};
        vecs[7]  = '{ALU_DIV, 32'd5,          32'd0,       32'hFFFFFFFF};
        vecs[8]  = '{ALU_MOD, 32'd5,          32'd0,       32'd5};
        vecs[9]  = '{ALU_MOD, 32'hDEADBEEF,   32'h10,      32'hF};
        vecs[10] = '{4'h0,    32'd3,          32'd4,       32'h0};

        repeat (2) @(posedge i_clk);
        @(negedge i_clk);
        check("reset_ready", {31'b0, o_ready}, 32'd1);
        check("reset_valid", {31'b0, o_valid}, 32'd0);
        check("reset_res",   o_res, 32'd0);
        i_rst_n = 1'b1;
        i_ready = 1'b1;

        for (int i = 0; i < 11; i++) begin
            issue(vecs[i].ctl, vecs[i].op1, vecs[i].op2, vecs[i].exp, 1'b1);
            wait_result($sformatf("vec%0d", i));
            drain($sformatf("vec%0d", i));
        end

        // Back-pressure: DONE held, stray request must not be taken.
        i_ready = 1'b0;
        bp_exp = 32'd391;
        issue(ALU_MUL, 32'd17, 32'd23, bp_exp, 1'b1);
        wait_result("bp");
        for (int c = 0; c < 10; c++) begin
            i_valid = (c == 3);
            i_ctl   = ALU_MUL;
            i_op1   = 32'd2;
            i_op2   = 32'd3;
            @(posedge i_clk);
            @(negedge i_clk);
            check("bp_res_hold", o_res, bp_exp);
            check("bp_state", {30'b0, o_ready, o_valid}, 32'd1);
        end
        i_valid = 1'b0;
        drain("bp");
        repeat (5) @(posedge i_clk);
        @(negedge i_clk);
        check("bp_no_stray", {30'b0, o_ready, o_valid}, 32'd2);

        // Reset ten cycles into a divide.
        issue(ALU_DIV, 32'd1000, 32'd3, 32'd333, 1'b0);
        repeat (9) @(posedge i_clk);
        @(negedge i_clk);
        i_rst_n = 1'b0;
        @(posedge i_clk);
        @(negedge i_clk);
        i_rst_n = 1'b1;
        check("rst_mid_ready", {31'b0, o_ready}, 32'd1);
        check("rst_mid_valid", {31'b0, o_valid}, 32'd0);
        check("rst_mid_res",   o_res, 32'd0);
        repeat (40) @(posedge i_clk);
        @(negedge i_clk);
        check("rst_no_result", {30'b0, o_ready, o_valid}, 32'd2);
        issue(ALU_MOD, 32'd17, 32'd5, 32'd2, 1'b1);
        wait_result("post_rst_mod");
        drain("post_rst_mod");
        check("sb_empty_end", 32'(sb_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
